ika87ad_opcode_sequencer: RTL

IKA87AD_OPCODE_SEQUENCER -- requirements
Module: ika87ad_opcode_sequencer

---
 rtl/ika87ad_opcode_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ika87ad_opcode_sequencer.sv
// ika87ad_opcode_sequencer
// Turns a stream of fetched opcode bytes into a queue of microcode start
// addresses. Prefix bytes (48/60/64/70/74) select an opcode page for the
// byte that follows them. The external combinational decoder sees the
// current opcode/page and returns the start address, which is queued
// together with its page. Hardware interrupts inject a fixed start address.
//
// Build option: define IKA87AD_OPSEQ_FIFO_EN to make the output queue a
// 2-entry FIFO; otherwise it is a single output register.
module ika87ad_opcode_sequencer #(
    parameter int unsigned              SA_WIDTH   = 8,
    parameter int unsigned              PAGE_WIDTH = 3,
    parameter logic [SA_WIDTH-1:0]      HARDI_SA   = 8'hF0
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_RESET_n,

    input  logic [7:0]              i_OP_BYTE,
    input  logic                    i_OP_VALID,
    output logic                    o_OP_READY,

    input  logic                    i_IRQ,
    output logic                    o_IRQ_ACK,

    input  logic                    i_FLUSH,

    output logic [7:0]              o_DEC_OPCODE,
    output logic [PAGE_WIDTH-1:0]   o_DEC_PAGE,
    input  logic [SA_WIDTH-1:0]     i_DEC_SA,

    output logic [SA_WIDTH-1:0]     o_SA,
    output logic [PAGE_WIDTH-1:0]   o_SA_PAGE,
    output logic                    o_SA_VALID,
    input  logic                    i_SA_READY
);

    // Sequencer states: ST_BASE decodes on page 0, ST_PREFIX on the latched page.
    localparam logic [0:0] ST_BASE   = 1'b0;
    localparam logic [0:0] ST_PREFIX = 1'b1;

    logic [0:0]            state_q,     state_d;
    logic [PAGE_WIDTH-1:0] page_q,      page_d;
    // Interrupts are re-armed only once a real opcode has gone through, so a
    // level IRQ held high cannot starve the instruction stream.
    logic                  irq_armed_q, irq_armed_d;

    logic                  is_prefix;
    logic [PAGE_WIDTH-1:0] prefix_page;
    logic                  can_accept;
    logic                  irq_take;
    logic                  byte_acc;
    logic                  q_wr;
    logic                  q_rd;
    logic [SA_WIDTH-1:0]   q_wr_sa;
    logic [PAGE_WIDTH-1:0] q_wr_page;

    // Classify the incoming byte as a prefix and look up the page it selects.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_prefix   = 1'b1;
        prefix_page = '0;
        case (i_OP_BYTE)
            8'h48:   prefix_page = PAGE_WIDTH'(1);
            8'h60:   prefix_page = PAGE_WIDTH'(2);
            8'h64:   prefix_page = PAGE_WIDTH'(3);
            8'h70:   prefix_page = PAGE_WIDTH'(4);
            8'h74:   prefix_page = PAGE_WIDTH'(5);
            default: is_prefix   = 1'b0;
        endcase
    end

    // The decoder always sees the live byte; the page register is held at 0
    // outside ST_PREFIX, so it can be presented directly.
    assign o_DEC_OPCODE = i_OP_BYTE;
    assign o_DEC_PAGE   = page_q;

    // An interrupt is taken only between instructions and only if it can be
    // queued; flush and reset suppress it.
    assign irq_take   = i_RESET_n && !i_FLUSH && (state_q == ST_BASE) &&
                        can_accept && i_IRQ && irq_armed_q;
    assign o_IRQ_ACK  = irq_take;
    assign o_OP_READY = i_RESET_n && !i_FLUSH && !irq_take && can_accept;
    assign byte_acc   = i_OP_VALID && o_OP_READY;

    // Queue write/read requests. A prefix byte in ST_BASE only sets up the page.
    always_comb begin
        q_wr      = 1'b0;
        q_wr_sa   = i_DEC_SA;
        q_wr_page = page_q;
        if (irq_take) begin
            q_wr      = 1'b1;
            q_wr_sa   = HARDI_SA;
            q_wr_page = '0;
        end else if (byte_acc && ((state_q == ST_PREFIX) || !is_prefix)) begin
            q_wr      = 1'b1;
        end
    end

    assign q_rd = o_SA_VALID && i_SA_READY;

    // Next-state logic for the prefix FSM, page register and interrupt arming.
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        irq_armed_d = irq_armed_q;
        if (i_FLUSH) begin
            state_d = ST_BASE;
            page_d  = '0;
        end else if (irq_take) begin
            irq_armed_d = 1'b0;
        end else if (byte_acc) begin
            if ((state_q == ST_BASE) && is_prefix) begin
                state_d = ST_PREFIX;
                page_d  = prefix_page;
            end else begin
                state_d     = ST_BASE;
                page_d      = '0;
                irq_armed_d = 1'b1;
            end
        end
    end

    // Register the FSM, page and interrupt arming with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RESET_n) begin
            state_q     <= ST_BASE;
            page_q      <= '0;
            irq_armed_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            irq_armed_q <= irq_armed_d;
        end
    end

`ifdef IKA87AD_OPSEQ_FIFO_EN

    logic [SA_WIDTH-1:0]   fifo_sa_q   [2];
    logic [PAGE_WIDTH-1:0] fifo_page_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;

    assign can_accept = (count_q != 2'd2);
    assign o_SA_VALID = (count_q != 2'd0);
    assign o_SA       = fifo_sa_q[rd_ptr_q];
    assign o_SA_PAGE  = fifo_page_q[rd_ptr_q];

    // Two-entry FIFO; a write and a read in the same cycle keep the count.
    // NOTE: the storage is reset as well because o_SA/o_SA_PAGE show the
    // head entry directly and must read as zero after reset.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RESET_n) begin
            fifo_sa_q[0]   <= '0;
            fifo_sa_q[1]   <= '0;
            fifo_page_q[0] <= '0;
            fifo_page_q[1] <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else if (i_FLUSH) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (q_wr) begin
                fifo_sa_q[wr_ptr_q]   <= q_wr_sa;
                fifo_page_q[wr_ptr_q] <= q_wr_page;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (q_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({q_wr, q_rd})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`else

    logic [SA_WIDTH-1:0]   sa_q;
    logic [PAGE_WIDTH-1:0] sa_page_q;
    logic                  sa_valid_q;

    // A single slot can be refilled in the same cycle it is consumed.
    assign can_accept = !sa_valid_q || i_SA_READY;
    assign o_SA_VALID = sa_valid_q;
    assign o_SA       = sa_q;
    assign o_SA_PAGE  = sa_page_q;

    // Single output register; a write overrides a simultaneous read.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RESET_n) begin
            sa_q       <= '0;
            sa_page_q  <= '0;
            sa_valid_q <= 1'b0;
        end else if (i_FLUSH) begin
            sa_valid_q <= 1'b0;
        end else if (q_wr) begin
            sa_q       <= q_wr_sa;
            sa_page_q  <= q_wr_page;
            sa_valid_q <= 1'b1;
        end else if (q_rd) begin
            sa_valid_q <= 1'b0;
        end
    end

`endif

endmodule
